dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory of the single-cycle RISC-V core. It shares the memory between the core load/store path and a loader/DMA port (program preload, debug peek/poke). It raises a stall toward the core whenever the core loses a cycle. The core holds its PC and register-file write while stalled. The block sits between the core's ALU-result/RD2 nets and `data_memory`.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/loader requesters, the data-memory arbiter and the data memory.
// The arbiter connects through the slave modport; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic [DATA_W-1:0] c_rdata;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_stall, c_rdata,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    output l_gnt, l_rdata,
    output mem_wr_en, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_stall, c_rdata,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    input  l_gnt, l_rdata,
    input  mem_wr_en, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Zero-latency arbiter sharing the single-port data memory between the core and the loader/DMA port.
// Define DMEM_ARB_FAIRNESS_EN to add the forced loader grant after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic           clock,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CORE_OWN, LOAD_OWN} owner_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_params
      $error("dmem_arbiter: STARVE_LIMIT and LOCK_MAX must lie in 1..255");
    end
  endgenerate

  owner_t            owner;
  logic [7:0]        lock_cnt;
  logic              c_gnt;
  logic              l_gnt;
  logic              lock_hold;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;
`endif

  assign lock_hold = (owner == LOAD_OWN) && bus.l_req && bus.l_lock && (lock_cnt < LOCK_MAX_C);

  // Priority chain: reset, lock hold, fairness force, core, loader.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst) begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
    end else if (lock_hold) begin
      l_gnt = 1'b1;
`ifdef DMEM_ARB_FAIRNESS_EN
    end else if (bus.l_req && (starve_cnt == STARVE_LIMIT_C)) begin
      l_gnt = 1'b1;
`endif
    end else if (bus.c_req) begin
      c_gnt = 1'b1;
    end else if (bus.l_req) begin
      l_gnt = 1'b1;
    end
  end

  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (c_gnt) begin
      mux_we    = bus.c_we;
      mux_addr  = bus.c_addr;
      mux_wdata = bus.c_wdata;
    end else if (l_gnt) begin
      mux_we    = bus.l_we;
      mux_addr  = bus.l_addr;
      mux_wdata = bus.l_wdata;
    end
  end

  assign bus.c_gnt          = c_gnt;
  assign bus.l_gnt          = l_gnt;
  assign bus.c_stall        = bus.c_req & ~c_gnt;
  assign bus.c_rdata        = bus.mem_read_data;
  assign bus.l_rdata        = bus.mem_read_data;
  assign bus.mem_wr_en      = mux_we;
  assign bus.mem_addr       = mux_addr;
  assign bus.mem_write_data = mux_wdata;

  // lock_cnt counts the current loader burst length including this cycle; 0 means no burst.
  always_ff @(posedge clock) begin
    if (rst) begin
      owner    <= IDLE;
      lock_cnt <= 8'd0;
`ifdef DMEM_ARB_FAIRNESS_EN
      starve_cnt <= 8'd0;
`endif
    end else begin
      if (l_gnt) begin
        owner <= LOAD_OWN;
      end else if (c_gnt) begin
        owner <= CORE_OWN;
      end else begin
        owner <= IDLE;
      end

      if (!l_gnt) begin
        lock_cnt <= 8'd0;
      end else if (owner != LOAD_OWN) begin
        lock_cnt <= 8'd1;
      end else if (lock_cnt < LOCK_MAX_C) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

`ifdef DMEM_ARB_FAIRNESS_EN
      if (bus.l_req && !l_gnt) begin
        if (starve_cnt < STARVE_LIMIT_C) begin
          starve_cnt <= starve_cnt + 8'd1;
        end
      end else begin
        starve_cnt <= 8'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic against a
// history-based reference model and a shadow copy of the data memory.
module tb_dmem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 8;
  localparam int LOCK_MAX     = 16;

  typedef struct {
    bit          rst;
    bit          c_req;
    bit          c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    bit          l_req;
    bit          l_we;
    bit          l_lock;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
  } stim_t;

  logic  clock = 1'b0;
  logic  rst;
  stim_t cur;

  int errors = 0;
  int checks = 0;

  // 0 = no grant, 1 = core, 2 = loader; one entry per cycle since the last reset.
  byte         grantHist[$];
  bit          deniedHist[$];
  logic [31:0] modelMem[64];
  logic [31:0] ram[64];
  byte         lastGrant;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus)
  );

  assign bus.mem_read_data = ram[bus.mem_addr[7:2]];

  always @(posedge clock) begin
    if (bus.mem_wr_en) ram[bus.mem_addr[7:2]] <= bus.mem_write_data;
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int loaderRun();
    int n = 0;
    for (int i = grantHist.size() - 1; i >= 0 && grantHist[i] == 2; i--) n++;
    return n;
  endfunction

  function automatic int starveRun();
    int n = 0;
    for (int i = deniedHist.size() - 1; i >= 0 && deniedHist[i]; i--) n++;
    return n;
  endfunction

  function automatic byte predictGrant();
    bit prevLoader;
    prevLoader = (grantHist.size() > 0) && (grantHist[grantHist.size() - 1] == 2);
    if (cur.rst) return 0;
    if (prevLoader && cur.l_req && cur.l_lock && loaderRun() < LOCK_MAX) return 2;
`ifdef DMEM_ARB_FAIRNESS_EN
    if (cur.l_req && starveRun() >= STARVE_LIMIT) return 2;
`endif
    if (cur.c_req) return 1;
    if (cur.l_req) return 2;
    return 0;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clock);
    #1;
    cur         = s;
    rst         = s.rst;
    bus.c_req   = s.c_req;
    bus.c_we    = s.c_we;
    bus.c_addr  = s.c_addr;
    bus.c_wdata = s.c_wdata;
    bus.l_req   = s.l_req;
    bus.l_we    = s.l_we;
    bus.l_lock  = s.l_lock;
    bus.l_addr  = s.l_addr;
    bus.l_wdata = s.l_wdata;
  endtask

  task automatic checkOutput();
    byte         g;
    bit          expWe;
    logic [31:0] expAddr;
    logic [31:0] expData;
    #3;
    g       = predictGrant();
    expWe   = 1'b0;
    expAddr = '0;
    expData = '0;
    if (g == 1) begin
      expWe = cur.c_we; expAddr = cur.c_addr; expData = cur.c_wdata;
    end else if (g == 2) begin
      expWe = cur.l_we; expAddr = cur.l_addr; expData = cur.l_wdata;
    end
    compare("c_gnt", 32'(bus.c_gnt), 32'(g == 1));
    compare("l_gnt", 32'(bus.l_gnt), 32'(g == 2));
    compare("c_stall", 32'(bus.c_stall), 32'(cur.c_req && g != 1));
    compare("mem_wr_en", 32'(bus.mem_wr_en), 32'(expWe));
    compare("mem_addr", bus.mem_addr, expAddr);
    compare("mem_write_data", bus.mem_write_data, expData);
    if (g == 1 && !cur.c_we) compare("c_rdata", bus.c_rdata, modelMem[cur.c_addr[7:2]]);
    if (g == 2 && !cur.l_we) compare("l_rdata", bus.l_rdata, modelMem[cur.l_addr[7:2]]);

    lastGrant = g;
    if (cur.rst) begin
      grantHist.delete();
      deniedHist.delete();
    end else begin
      grantHist.push_back(g);
      deniedHist.push_back(cur.l_req && g != 2);
      if (grantHist.size() > 300) begin
        void'(grantHist.pop_front());
        void'(deniedHist.pop_front());
      end
      if (expWe) modelMem[expAddr[7:2]] = expData;
    end
  endtask

  function automatic stim_t mk(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                               input logic [31:0] cd, input bit lr, input bit lw, input bit lk,
                               input logic [31:0] la, input logic [31:0] ld);
    stim_t s;
    s.rst = r; s.c_req = cr; s.c_we = cw; s.c_addr = ca; s.c_wdata = cd;
    s.l_req = lr; s.l_we = lw; s.l_lock = lk; s.l_addr = la; s.l_wdata = ld;
    return s;
  endfunction

  task automatic step(input stim_t s);
    applyStimulus(s);
    checkOutput();
  endtask

  initial begin
    int    idx;
    int    lGrants;
    stim_t s;

    for (int i = 0; i < 64; i++) begin
      ram[i]      = '0;
      modelMem[i] = '0;
    end
    rst = 1'b1;
    cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with both requesters active: no grant, memory side idle, core stalled.
    step(mk(1, 1, 1, 32'h10, 32'h1111_1111, 1, 1, 1, 32'h20, 32'h2222_2222));
    step(mk(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0));

    // Core store then load of the same word.
    step(mk(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0));
    compare("core_readback", bus.c_rdata, 32'hDEAD_BEEF);

    // Contention without lock: core wins three times.
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 32'h5555_0000 + i));

    // Both requesting continuously from a clean start.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    lGrants = 0;
    for (int i = 0; i < 18; i++) begin
      step(mk(0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h44, 32'hA000_0000 + i));
      if (bus.l_gnt) lGrants++;
    end
`ifdef DMEM_ARB_FAIRNESS_EN
    compare("fairness_loader_grants", 32'(lGrants), 32'd2);
`else
    compare("fairness_loader_grants", 32'(lGrants), 32'd0);
`endif

    // Locked burst: loader starts while the core is idle, then the core requests throughout.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idx = 0;
    for (int i = 0; i < 22; i++) begin
      s = mk(0, i != 0, 0, 32'h80, 0, idx < 20, 1, 1, 32'(idx * 4), 32'hB000_0000 + 32'(idx));
      step(s);
      if (lastGrant == 2) idx++;
    end
    compare("burst_words_written", 32'(idx), 32'(LOCK_MAX));
    for (int i = 0; i < 16; i++) step(mk(0, 1, 0, 32'(i * 4), 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a locked burst.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'hC0, 32'hC0C0_0000));
    for (int i = 1; i < 5; i++) step(mk(0, 1, 0, 32'h10, 0, 1, 1, 1, 32'(32'hC0 + i * 4), 32'hC0C0_0000 + i));
    step(mk(1, 1, 0, 32'h10, 0, 1, 1, 1, 32'hD4, 32'hC0C0_0005));
    step(mk(0, 1, 0, 32'h10, 0, 1, 1, 1, 32'hD4, 32'hC0C0_0005));
    compare("post_reset_core_wins", 32'(bus.c_gnt), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s.rst     = ($urandom_range(0, 99) < 2);
      s.c_req   = ($urandom_range(0, 99) < 60);
      s.c_we    = $urandom_range(0, 1);
      s.c_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      s.c_wdata = $urandom;
      s.l_req   = ($urandom_range(0, 99) < 65);
      s.l_we    = $urandom_range(0, 1);
      s.l_lock  = ($urandom_range(0, 99) < 75);
      s.l_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      s.l_wdata = $urandom;
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
